// File: rtl/pipelined_control_unit_pkg.sv
// pipelined_control_unit_pkg: MIPS opcode, funct and ALU-control encodings shared by the decoder and the control pipeline
package pipelined_control_unit_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;
endpackage

// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if: master drives Opcode/Funct/FlushE; slave (control unit) returns D flags, E/M/W control and IllegalSeen/RetiredCnt
interface pipelined_control_unit_if #(
  parameter int OPCODE_W  = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 32
);
  logic [OPCODE_W-1:0]  Opcode;
  logic [FUNCT_W-1:0]   Funct;
  logic                 FlushE;
  logic                 JumpD;
  logic                 BranchD;
  logic                 BranchNeD;
  logic                 ZeroExtD;
  logic                 IllegalD;
  logic                 RegWriteE;
  logic                 MemtoRegE;
  logic                 MemWriteE;
  logic                 ALUSrcE;
  logic                 RegDstE;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic                 RegWriteM;
  logic                 MemtoRegM;
  logic                 MemWriteM;
  logic                 RegWriteW;
  logic                 MemtoRegW;
  logic                 IllegalSeen;
  logic [CNT_W-1:0]     RetiredCnt;
  modport master (
    output Opcode, Funct, FlushE,
    input  JumpD, BranchD, BranchNeD, ZeroExtD, IllegalD,
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
    input  RegWriteM, MemtoRegM, MemWriteM, RegWriteW, MemtoRegW,
    input  IllegalSeen, RetiredCnt
  );
  modport slave (
    input  Opcode, Funct, FlushE,
    output JumpD, BranchD, BranchNeD, ZeroExtD, IllegalD,
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
    output RegWriteM, MemtoRegM, MemWriteM, RegWriteW, MemtoRegW,
    output IllegalSeen, RetiredCnt
  );
endinterface

// File: rtl/pipelined_control_unit_control_decode.sv
// control_decode: combinational main+ALU decode; opcode_i/funct_i in, D-stage flags plus the valid/control bundle for E out
module control_decode
  import pipelined_control_unit_pkg::*;
#(
  parameter int OPCODE_W  = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3,
  parameter int EXT_ISA   = 1
) (
  input  logic [OPCODE_W-1:0]  opcode_i,
  input  logic [FUNCT_W-1:0]   funct_i,
  output logic                 jump_o,
  output logic                 branch_o,
  output logic                 branch_ne_o,
  output logic                 zero_ext_o,
  output logic                 illegal_o,
  output logic                 valid_o,
  output logic                 reg_write_o,
  output logic                 mem_to_reg_o,
  output logic                 mem_write_o,
  output logic                 alu_src_o,
  output logic                 reg_dst_o,
  output logic [ALUCTRL_W-1:0] alu_ctrl_o
);
  localparam bit EXT = EXT_ISA != 0;
  logic is_r, is_lw, is_sw, is_addi, is_beq, is_j, is_andi, is_ori, is_slti, is_bne;
  logic fn_sub, fn_and, fn_or, fn_slt, fn_ok;
  logic [2:0] r_alu, alu;
  assign is_r    = opcode_i == OPCODE_W'(OP_RTYPE);
  assign is_lw   = opcode_i == OPCODE_W'(OP_LW);
  assign is_sw   = opcode_i == OPCODE_W'(OP_SW);
  assign is_addi = opcode_i == OPCODE_W'(OP_ADDI);
  assign is_beq  = opcode_i == OPCODE_W'(OP_BEQ);
  assign is_j    = opcode_i == OPCODE_W'(OP_J);
  assign is_andi = EXT && opcode_i == OPCODE_W'(OP_ANDI);
  assign is_ori  = EXT && opcode_i == OPCODE_W'(OP_ORI);
  assign is_slti = EXT && opcode_i == OPCODE_W'(OP_SLTI);
  assign is_bne  = EXT && opcode_i == OPCODE_W'(OP_BNE);
  assign fn_sub  = funct_i == FUNCT_W'(FN_SUB);
  assign fn_and  = funct_i == FUNCT_W'(FN_AND);
  assign fn_or   = funct_i == FUNCT_W'(FN_OR);
  assign fn_slt  = funct_i == FUNCT_W'(FN_SLT);
  assign fn_ok   = fn_sub | fn_and | fn_or | fn_slt | (funct_i == FUNCT_W'(FN_ADD));
  always_comb begin
    r_alu = fn_sub ? ALU_SUB : fn_and ? ALU_AND : fn_or ? ALU_OR : fn_slt ? ALU_SLT : ALU_ADD;
    alu = is_r ? r_alu :
          (is_beq | is_bne) ? ALU_SUB :
          is_andi ? ALU_AND :
          is_ori ? ALU_OR :
          is_slti ? ALU_SLT :
          (is_lw | is_sw | is_addi) ? ALU_ADD : 3'b000;
    valid_o      = is_r | is_lw | is_sw | is_addi | is_beq | is_j | is_andi | is_ori | is_slti | is_bne;
    illegal_o    = !valid_o || (is_r && !fn_ok);
    jump_o       = is_j;
    branch_o     = is_beq;
    branch_ne_o  = is_bne;
    zero_ext_o   = is_andi | is_ori;
    reg_write_o  = is_r | is_lw | is_addi | is_andi | is_ori | is_slti;
    mem_to_reg_o = is_lw;
    mem_write_o  = is_sw;
    alu_src_o    = is_lw | is_sw | is_addi | is_andi | is_ori | is_slti;
    reg_dst_o    = is_r;
    alu_ctrl_o   = ALUCTRL_W'(alu);
  end
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: D decode feeding E/M/W control registers, sticky IllegalSeen and retired counter; CLK/RST plain, everything else on bus
module pipelined_control_unit
  import pipelined_control_unit_pkg::*;
#(
  parameter int OPCODE_W  = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3,
  parameter int EXT_ISA   = 1,
  parameter int CNT_W     = 32
) (
  input logic                    CLK,
  input logic                    RST,
  pipelined_control_unit_if.slave bus
);
  localparam int EW = ALUCTRL_W + 6;
  logic dec_valid, dec_rw, dec_m2r, dec_mw, dec_as, dec_rd;
  logic [ALUCTRL_W-1:0] dec_alu;
  logic [EW-1:0] e_d, e_q;
  logic [3:0] m_q;
  logic [2:0] w_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic seen_d, seen_q;
  control_decode #(
    .OPCODE_W(OPCODE_W), .FUNCT_W(FUNCT_W), .ALUCTRL_W(ALUCTRL_W), .EXT_ISA(EXT_ISA)
  ) u_dec (
    .opcode_i(bus.Opcode), .funct_i(bus.Funct),
    .jump_o(bus.JumpD), .branch_o(bus.BranchD), .branch_ne_o(bus.BranchNeD),
    .zero_ext_o(bus.ZeroExtD), .illegal_o(bus.IllegalD),
    .valid_o(dec_valid), .reg_write_o(dec_rw), .mem_to_reg_o(dec_m2r),
    .mem_write_o(dec_mw), .alu_src_o(dec_as), .reg_dst_o(dec_rd), .alu_ctrl_o(dec_alu)
  );
  always_comb begin
    e_d    = bus.FlushE ? '0 : {dec_valid, dec_rw, dec_m2r, dec_mw, dec_as, dec_rd, dec_alu};
    cnt_d  = cnt_q + CNT_W'(w_q[2]);
    seen_d = seen_q | (bus.IllegalD & ~bus.FlushE);
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      e_q    <= e_d;
      m_q    <= e_q[EW-1 -: 4];
      w_q    <= m_q[3:1];
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
    end
  end
  assign {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ALUSrcE, bus.RegDstE, bus.ALUControlE} = e_q[EW-2:0];
  assign {bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM} = m_q[2:0];
  assign {bus.RegWriteW, bus.MemtoRegW} = w_q[1:0];
  assign bus.IllegalSeen = seen_q;
  assign bus.RetiredCnt  = cnt_q;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed and random stimulus on EXT_ISA=1/CNT_W=4 and EXT_ISA=0/CNT_W=32 units against a table-driven pipeline model
module tb_pipelined_control_unit;
  typedef struct packed {logic valid, rw, m2r, mw, as, rd; logic [2:0] alu;} bun_t;
  typedef struct packed {logic jump, br, bne, zext, ill; bun_t b;} dec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opc = '0;
  logic [5:0] fun = '0;
  logic flush = 1'b0;
  int total = 0;
  int bad = 0;
  bun_t st [2][3];
  int unsigned cnt [2];
  logic seen [2];
  dec_t dd [2];
  always #5 clk = ~clk;
  pipelined_control_unit_if #(.CNT_W(4)) ia ();
  pipelined_control_unit_if ib ();
  assign ia.Opcode = opc;
  assign ia.Funct  = fun;
  assign ia.FlushE = flush;
  assign ib.Opcode = opc;
  assign ib.Funct  = fun;
  assign ib.FlushE = flush;
  pipelined_control_unit #(.EXT_ISA(1), .CNT_W(4)) dut_a (.CLK(clk), .RST(rst_n), .bus(ia));
  pipelined_control_unit #(.EXT_ISA(0)) dut_b (.CLK(clk), .RST(rst_n), .bus(ib));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic dec_t ref_dec(input logic [5:0] op, input logic [5:0] fn, input bit ext);
    dec_t d = '0;
    case (op)
      6'b100011: d.b = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010};
      6'b101011: d.b = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010};
      6'b001000: d.b = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010};
      6'b000100: begin d.b = {1'b1, 5'b00000, 3'b110}; d.br = 1'b1; end
      6'b000010: begin d.b = {1'b1, 5'b00000, 3'b000}; d.jump = 1'b1; end
      6'b000000: begin
        d.b = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010};
        case (fn)
          6'b100000: d.b.alu = 3'b010;
          6'b100010: d.b.alu = 3'b110;
          6'b100100: d.b.alu = 3'b000;
          6'b100101: d.b.alu = 3'b001;
          6'b101010: d.b.alu = 3'b111;
          default:   d.ill = 1'b1;
        endcase
      end
      6'b001100: if (ext) begin d.b = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000}; d.zext = 1'b1; end else d.ill = 1'b1;
      6'b001101: if (ext) begin d.b = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001}; d.zext = 1'b1; end else d.ill = 1'b1;
      6'b001010: if (ext) d.b = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111}; else d.ill = 1'b1;
      6'b000101: if (ext) begin d.b = {1'b1, 5'b00000, 3'b110}; d.bne = 1'b1; end else d.ill = 1'b1;
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction
  function automatic logic [7:0] efld(input bun_t b);
    return {b.rw, b.m2r, b.mw, b.as, b.rd, b.alu};
  endfunction
  task automatic model_reset();
    for (int x = 0; x < 2; x++) begin
      for (int k = 0; k < 3; k++) st[x][k] = '0;
      cnt[x] = 0;
      seen[x] = 1'b0;
    end
  endtask
  task automatic chk_pipe();
    check("eA", 32'({ia.RegWriteE, ia.MemtoRegE, ia.MemWriteE, ia.ALUSrcE, ia.RegDstE, ia.ALUControlE}), 32'(efld(st[0][0])));
    check("eB", 32'({ib.RegWriteE, ib.MemtoRegE, ib.MemWriteE, ib.ALUSrcE, ib.RegDstE, ib.ALUControlE}), 32'(efld(st[1][0])));
    check("mA", 32'({ia.RegWriteM, ia.MemtoRegM, ia.MemWriteM}), 32'({st[0][1].rw, st[0][1].m2r, st[0][1].mw}));
    check("mB", 32'({ib.RegWriteM, ib.MemtoRegM, ib.MemWriteM}), 32'({st[1][1].rw, st[1][1].m2r, st[1][1].mw}));
    check("wA", 32'({ia.RegWriteW, ia.MemtoRegW}), 32'({st[0][2].rw, st[0][2].m2r}));
    check("wB", 32'({ib.RegWriteW, ib.MemtoRegW}), 32'({st[1][2].rw, st[1][2].m2r}));
    check("cntA", 32'(ia.RetiredCnt), cnt[0] % 16);
    check("cntB", ib.RetiredCnt, cnt[1]);
    check("seenA", 32'(ia.IllegalSeen), 32'(seen[0]));
    check("seenB", 32'(ib.IllegalSeen), 32'(seen[1]));
  endtask
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic fl);
    opc = op;
    fun = fn;
    flush = fl;
    dd[0] = ref_dec(op, fn, 1'b1);
    dd[1] = ref_dec(op, fn, 1'b0);
    #1;
    check("dA", 32'({ia.JumpD, ia.BranchD, ia.BranchNeD, ia.ZeroExtD, ia.IllegalD}),
          32'({dd[0].jump, dd[0].br, dd[0].bne, dd[0].zext, dd[0].ill}));
    check("dB", 32'({ib.JumpD, ib.BranchD, ib.BranchNeD, ib.ZeroExtD, ib.IllegalD}),
          32'({dd[1].jump, dd[1].br, dd[1].bne, dd[1].zext, dd[1].ill}));
  endtask
  task automatic tick();
    @(posedge clk);
    for (int x = 0; x < 2; x++) begin
      if (st[x][2].valid) cnt[x]++;
      if (dd[x].ill && !flush) seen[x] = 1'b1;
      st[x][2] = st[x][1];
      st[x][1] = st[x][0];
      st[x][0] = flush ? '0 : dd[x].b;
    end
    @(negedge clk);
    chk_pipe();
  endtask
  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(6'b100011, 6'b000000, 1'b1);
      tick();
    end
  endtask
  initial begin
    logic [5:0] ops [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100,
                             6'b000010, 6'b001100, 6'b001101, 6'b001010, 6'b000101};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    model_reset();
    #2;
    chk_pipe();
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'b100011, 6'b000000, 1'b0);
    tick();
    check("lw_rwE", 32'(ia.RegWriteE), 1);
    check("lw_m2rE", 32'(ia.MemtoRegE), 1);
    check("lw_asE", 32'(ia.ALUSrcE), 1);
    check("lw_aluE", 32'(ia.ALUControlE), 32'h2);
    bubbles(2);
    check("lw_rwW", 32'(ia.RegWriteW), 1);
    check("lw_m2rW", 32'(ia.MemtoRegW), 1);
    bubbles(1);
    check("lw_cnt", 32'(ia.RetiredCnt), 1);
    drive(6'b000000, 6'b101010, 1'b0);
    tick();
    check("slt_aluE", 32'(ia.ALUControlE), 32'h7);
    check("slt_rdE", 32'(ia.RegDstE), 1);
    drive(6'b000000, 6'b111111, 1'b0);
    check("badfn_illD", 32'(ia.IllegalD), 1);
    tick();
    check("badfn_seen", 32'(ia.IllegalSeen), 1);
    bubbles(3);
    drive(6'b101011, 6'b000000, 1'b1);
    tick();
    check("swfl_mwE", 32'(ia.MemWriteE), 0);
    bubbles(1);
    check("swfl_mwM", 32'(ia.MemWriteM), 0);
    bubbles(2);
    check("swfl_cnt", ib.RetiredCnt, 3);
    drive(6'b001101, 6'b000000, 1'b0);
    check("ori_zextA", 32'(ia.ZeroExtD), 1);
    check("ori_illA", 32'(ia.IllegalD), 0);
    check("ori_illB", 32'(ib.IllegalD), 1);
    tick();
    check("ori_aluE", 32'(ia.ALUControlE), 32'h1);
    check("ori_bundleB", 32'({ib.RegWriteE, ib.MemtoRegE, ib.MemWriteE, ib.ALUSrcE, ib.RegDstE, ib.ALUControlE}), 0);
    drive(6'b001000, 6'b000000, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_rwE", 32'(ia.RegWriteE), 0);
    check("rst_rwM", 32'(ia.RegWriteM), 0);
    check("rst_rwW", 32'(ia.RegWriteW), 0);
    chk_pipe();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(6'b001000, 6'b000000, 1'b0);
      tick();
    end
    bubbles(3);
    check("wrapA", 32'(ia.RetiredCnt), 0);
    check("wrapB", ib.RetiredCnt, 16);
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      drive(op, fn, $urandom_range(0, 4) == 0);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
